// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                         |
// | Description : Bundle of request/response and byte-RAM signals        |
// |               between the memory arbiter and its environment.        |
// |               slave  = arbiter view, master = environment view.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  logic        rdy;
  logic        roll_back;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_push;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  rdy, roll_back,
    input  if_req, if_addr,
    output if_done, if_inst,
    input  ld_req, ld_addr, ld_size, ld_signed,
    output ld_done, ld_data,
    input  st_push, st_addr, st_data, st_size,
    output st_full,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, roll_back,
    output if_req, if_addr,
    input  if_done, if_inst,
    output ld_req, ld_addr, ld_size, ld_signed,
    input  ld_done, ld_data,
    output st_push, st_addr, st_data, st_size,
    input  st_full,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                            |
// | Description : Single-port byte-RAM arbiter for instruction fetch,    |
// |               loads and a 4-entry committed-store buffer. Stores     |
// |               always drain before a load or fetch starts.            |
// |               Option macro MEM_ARB_FETCH_PRIO_EN: when defined, the  |
// |               IDLE grant order is STORE > FETCH > LOAD instead of    |
// |               STORE > LOAD > FETCH.                                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_arbiter (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_FETCH = 2'd3;

  localparam logic [2:0] C_SB_DEPTH = 3'd4;
  localparam logic [2:0] C_WORD_N   = 3'd4;

  // store buffer
  logic [31:0] r_sb_addr [4];
  logic [31:0] r_sb_data [4];
  logic [1:0]  r_sb_size [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  // access engine
  logic [1:0]  r_state;
  logic [2:0]  r_k;
  logic [2:0]  r_n;
  logic [31:0] r_addr;
  logic [31:0] r_buf;
  logic        r_signed;
  logic        r_if_done;
  logic        r_ld_done;
  logic [31:0] r_if_inst;
  logic [31:0] r_ld_data;

  logic        w_sb_empty;
  logic        w_sb_full;
  logic        w_push;
  logic        w_pop;
  logic        w_store_last;
  logic        w_take_ld;
  logic        w_take_if;
  logic [31:0] w_head_addr;
  logic [31:0] w_head_data;
  logic [31:0] w_head_shift;
  logic [1:0]  w_head_size;
  logic [1:0]  w_cap_idx;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic [31:0] w_mem_a;
  logic [7:0]  w_mem_dout;
  logic        w_mem_wr;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return C_WORD_N;
    endcase
  endfunction

  assign w_sb_empty   = (r_count == 3'd0);
  assign w_sb_full    = (r_count == C_SB_DEPTH);
  assign w_head_addr  = r_sb_addr[r_rptr];
  assign w_head_data  = r_sb_data[r_rptr];
  assign w_head_size  = r_sb_size[r_rptr];
  assign w_head_shift = w_head_data >> {r_k[1:0], 3'b000};
  assign w_store_last = (r_state == S_STORE) && (r_k == (r_n - 3'd1));
  assign w_push       = bus.rdy && bus.st_push && !w_sb_full;
  assign w_pop        = bus.rdy && w_store_last;
  // byte arriving on mem_din belongs to the address issued one cycle earlier
  assign w_cap_idx    = r_k[1:0] - 2'd1;

  // IDLE grant; a non-empty buffer blocks both loads and fetches
  always_comb begin
    w_take_ld = 1'b0;
    w_take_if = 1'b0;
    if ((r_state == S_IDLE) && w_sb_empty && !bus.roll_back) begin
`ifdef MEM_ARB_FETCH_PRIO_EN
      if (bus.if_req)
        w_take_if = 1'b1;
      else if (bus.ld_req)
        w_take_ld = 1'b1;
`else
      if (bus.ld_req)
        w_take_ld = 1'b1;
      else if (bus.if_req)
        w_take_if = 1'b1;
`endif
    end
  end

  // merge the incoming RAM byte into the partially assembled word
  always_comb begin
    w_word = r_buf;
    case (w_cap_idx)
      2'd0:    w_word[7:0]   = bus.mem_din;
      2'd1:    w_word[15:8]  = bus.mem_din;
      2'd2:    w_word[23:16] = bus.mem_din;
      default: w_word[31:24] = bus.mem_din;
    endcase
  end

  // zero/sign extension of the load result from bit 8n-1
  always_comb begin
    case (r_n)
      3'd1:    w_ext = {{24{r_signed & w_word[7]}},  w_word[7:0]};
      3'd2:    w_ext = {{16{r_signed & w_word[15]}}, w_word[15:0]};
      default: w_ext = w_word;
    endcase
  end

  // RAM port: write only while draining a store, address only while bytes remain
  always_comb begin
    w_mem_a    = 32'd0;
    w_mem_dout = 8'd0;
    w_mem_wr   = 1'b0;
    case (r_state)
      S_STORE: begin
        w_mem_a    = w_head_addr + {29'd0, r_k};
        w_mem_dout = w_head_shift[7:0];
        w_mem_wr   = bus.rdy;
      end
      S_LOAD, S_FETCH: begin
        if (r_k < r_n)
          w_mem_a = r_addr + {29'd0, r_k};
      end
      default: ;
    endcase
  end

  // store-buffer payload; entries need no reset because count gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sb_addr[r_wptr] <= bus.st_addr;
      r_sb_data[r_wptr] <= bus.st_data;
      r_sb_size[r_wptr] <= bus.st_size;
    end
  end

  // store-buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 2'd1;
      if (w_pop)
        r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: ;
      endcase
    end
  end

  // access sequencer: store drain, load and fetch byte loops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= 3'd0;
      r_n       <= 3'd1;
      r_addr    <= 32'd0;
      r_buf     <= 32'd0;
      r_signed  <= 1'b0;
      r_if_done <= 1'b0;
      r_ld_done <= 1'b0;
      r_if_inst <= 32'd0;
      r_ld_data <= 32'd0;
    end else if (bus.rdy) begin
      r_if_done <= 1'b0;
      r_ld_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_k <= 3'd0;
          if (!w_sb_empty) begin
            r_state <= S_STORE;
            r_n     <= size_to_n(w_head_size);
          end else if (w_take_ld) begin
            r_state  <= S_LOAD;
            r_addr   <= bus.ld_addr;
            r_n      <= size_to_n(bus.ld_size);
            r_signed <= bus.ld_signed;
            r_buf    <= 32'd0;
          end else if (w_take_if) begin
            r_state  <= S_FETCH;
            r_addr   <= bus.if_addr;
            r_n      <= C_WORD_N;
            r_signed <= 1'b0;
            r_buf    <= 32'd0;
          end
        end
        S_STORE: begin
          if (w_store_last) begin
            r_state <= S_IDLE;
            r_k     <= 3'd0;
          end else begin
            r_k <= r_k + 3'd1;
          end
        end
        default: begin
          if (bus.roll_back) begin
            r_state <= S_IDLE;
            r_k     <= 3'd0;
          end else begin
            if (r_k != 3'd0)
              r_buf <= w_word;
            if (r_k == r_n) begin
              r_state <= S_IDLE;
              r_k     <= 3'd0;
              if (r_state == S_LOAD) begin
                r_ld_done <= 1'b1;
                r_ld_data <= w_ext;
              end else begin
                r_if_done <= 1'b1;
                r_if_inst <= w_word;
              end
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.st_full  = w_sb_full;
  assign bus.if_done  = r_if_done;
  assign bus.if_inst  = r_if_inst;
  assign bus.ld_done  = r_ld_done;
  assign bus.ld_data  = r_ld_data;
  assign bus.mem_a    = w_mem_a;
  assign bus.mem_dout = w_mem_dout;
  assign bus.mem_wr   = w_mem_wr;

endmodule
`default_nettype wire
